// File: rtl/btn_int_conditioner.sv
// Interrupt push-button conditioner: 2-flop synchronizer, press/release debounce, fixed-width pulse.
// Define PRESS_COUNTER_EN to build the 8-bit accepted-press counter; otherwise PRESS_COUNT is tied to zero.
module btn_int_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_IN,
    output logic       INT_OUT,
    output logic       BTN_LEVEL,
    output logic [2:0] STATE_DBG,
    output logic [7:0] PRESS_COUNT
);

    // The counter is shared by debounce and pulse timing, so it must hold the larger of the two.
    localparam int CNT_MAX = (PULSE_CYCLES > DEBOUNCE_CYCLES) ? PULSE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PUL_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_HI = 3'd1,
        PULSE   = 3'd2,
        HELD    = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    logic             sync_p0;
    logic             sync_p1;
    logic             s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Synchronizer stage: BTN_IN is asynchronous to CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= BTN_IN;
            sync_p1 <= sync_p0;
        end
    end

    assign s = sync_p1;

    // FSM stage: state and shared debounce/pulse counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = PULSE;
                end else begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            PULSE: begin
                // The button is ignored here so a short press still yields a full-width pulse.
                if (cnt == PUL_LAST) begin
                    state_nxt = HELD;
                end else begin
                    state_nxt = PULSE;
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    state_nxt = HELD;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_nxt = HELD;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output stage: decoded from next-state so the outputs line up with the state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            INT_OUT   <= 1'b0;
            BTN_LEVEL <= 1'b0;
        end else begin
            INT_OUT   <= (state_nxt == PULSE);
            BTN_LEVEL <= (state_nxt == PULSE) || (state_nxt == HELD) || (state_nxt == WAIT_LO);
        end
    end

    assign STATE_DBG = state;

`ifdef PRESS_COUNTER_EN
    logic       pulse_entry;
    logic [7:0] press_cnt;

    assign pulse_entry = (state_nxt == PULSE) && (state != PULSE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            press_cnt <= 8'h00;
        end else if (pulse_entry) begin
            press_cnt <= press_cnt + 8'd1;
        end
    end

    assign PRESS_COUNT = press_cnt;
`else
    assign PRESS_COUNT = 8'h00;
`endif

endmodule

// File: tb/tb_btn_int_conditioner.sv
// Scoreboard bench for btn_int_conditioner: a run-length reference model predicts every cycle's outputs.
module tb_btn_int_conditioner;

    localparam int DEB = 4;
    localparam int PUL = 2;

    logic       CLK;
    logic       RST_N;
    logic       BTN_IN;
    logic       INT_OUT;
    logic       BTN_LEVEL;
    logic [2:0] STATE_DBG;
    logic [7:0] PRESS_COUNT;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       intr;
        logic       lvl;
        logic [2:0] st;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];

    btn_int_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_CYCLES   (PUL)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .BTN_IN     (BTN_IN),
        .INT_OUT    (INT_OUT),
        .BTN_LEVEL  (BTN_LEVEL),
        .STATE_DBG  (STATE_DBG),
        .PRESS_COUNT(PRESS_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, req, $time);
        end
    endtask

    task automatic hold(input logic v, input int n);
        BTN_IN = v;
        repeat (n) @(negedge CLK);
    endtask

    // phase 0: released, 1: pulsing, 2: pressed; run = consecutive samples opposing the current level.
    function automatic exp_t expect_of(input int phase, input int run, input int presses);
        exp_t e;
        e.intr = (phase == 1);
        e.lvl  = (phase != 0);
        case (phase)
            0:       e.st = (run > 0) ? 3'd1 : 3'd0;
            1:       e.st = 3'd2;
            default: e.st = (run > 0) ? 3'd4 : 3'd3;
        endcase
        e.pc = 8'(presses);
`ifndef PRESS_COUNTER_EN
        e.pc = 8'h00;
`endif
        return e;
    endfunction

    initial begin : model
        logic d1, d2, sv;
        int phase, run, pdone, presses;
        d1 = 1'b0; d2 = 1'b0; sv = 1'b0;
        phase = 0; run = 0; pdone = 0; presses = 0;
        forever begin
            @(posedge CLK or negedge RST_N);
            if (RST_N !== 1'b1) begin
                d1 = 1'b0; d2 = 1'b0;
                phase = 0; run = 0; pdone = 0; presses = 0;
                exp_q.delete();
            end else begin
                sv = d2;
                d2 = d1;
                d1 = BTN_IN;
                case (phase)
                    0: begin
                        run = sv ? run + 1 : 0;
                        if (run == DEB) begin
                            phase = 1; run = 0; pdone = 0; presses++;
                        end
                    end
                    1: begin
                        pdone++;
                        if (pdone == PUL) begin
                            phase = 2; run = 0;
                        end
                    end
                    default: begin
                        run = !sv ? run + 1 : 0;
                        if (run == DEB) begin
                            phase = 0; run = 0;
                        end
                    end
                endcase
                exp_q.push_back(expect_of(phase, run, presses));
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got 0 entries expected 1 at time %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("int_out", INT_OUT, e.intr);
                    check("btn_level", BTN_LEVEL, e.lvl);
                    check("state_dbg", STATE_DBG, e.st);
                    check("press_count", PRESS_COUNT, e.pc);
                end
            end
        end
    end

    initial begin : stimulus
        int lat;
        int wd;
        int expc;
        RST_N  = 1'b0;
        BTN_IN = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_int", INT_OUT, 0);
        check("reset_level", BTN_LEVEL, 0);
        check("reset_state", STATE_DBG, 0);
        check("reset_count", PRESS_COUNT, 0);
        #1 RST_N = 1'b1;
        hold(1'b0, 4);

        // Clean press: INT_OUT first seen after edge DEB+1, i.e. DEB+2 rising edges from edge 0.
        BTN_IN = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (INT_OUT === 1'b1) break;
        end
        check("press_latency", lat, DEB + 2);
        wd = 0;
        while (INT_OUT === 1'b1 && wd < 40) begin
            @(negedge CLK);
            wd++;
        end
        check("pulse_width", wd, PUL);
        hold(1'b1, 4);
        hold(1'b0, 12);

        // Press bounce, release bounce, short press.
        hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 12);
        hold(1'b1, 12); hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 12);
        hold(1'b1, 5); hold(1'b0, 14);

        repeat (300) hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
        hold(1'b0, 12);

        // Asynchronous reset in the middle of a pulse, with the button still held at release.
        BTN_IN = 1'b1;
        wd = 0;
        while (INT_OUT !== 1'b1 && wd < 40) begin
            @(negedge CLK);
            wd++;
        end
        check("pulse_seen", INT_OUT, 1);
        #1 RST_N = 1'b0;
        #1;
        check("async_rst_int", INT_OUT, 0);
        check("async_rst_level", BTN_LEVEL, 0);
        check("async_rst_state", STATE_DBG, 0);
        check("async_rst_count", PRESS_COUNT, 0);
        repeat (3) @(negedge CLK);
        #1 RST_N = 1'b1;
        hold(1'b1, 12);
        hold(1'b0, 12);

        // Counter wrap over 256 clean presses from a fresh reset.
        #1 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        #1 RST_N = 1'b1;
        hold(1'b0, 2);
        for (int i = 0; i < 256; i++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
            if (i == 0 || i == 254 || i == 255) begin
                expc = (i + 1) % 256;
`ifndef PRESS_COUNTER_EN
                expc = 0;
`endif
                check("press_count_wrap", PRESS_COUNT, expc);
            end
        end
        hold(1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
